// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests one word at pc, holds it until decode consumes it,
// then advances pc sequentially or by a branch offset.
module fetch_unit #(
    parameter int                WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    input  logic             PCsrc,
    input  logic [WIDTH-1:0] ImmOp,
    output logic [WIDTH-1:0] pc,
    output logic [31:0]      retired
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] next_pc_raw;
    logic [WIDTH-1:0] next_pc;
    logic             consume;

    // Outputs are gated by rst_n so nothing is requested or presented while reset is held.
    assign imem_req    = rst_n && ((state == S_REQ) || (state == S_WAIT));
    assign instr_valid = rst_n && (state == S_HOLD);
    assign imem_addr   = pc;
    assign consume     = instr_valid && instr_ready;

    assign next_pc_raw = PCsrc ? (pc + ImmOp) : (pc + WIDTH'(4));
    assign next_pc     = {next_pc_raw[WIDTH-1:2], 2'b00};

    // NOTE: every register here uses non-blocking assignment so all state updates
    // see the pre-edge values of each other, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_REQ;
            pc      <= RESET_PC;
            instr   <= '0;
            retired <= '0;
        end else begin
            case (state)
                S_REQ, S_WAIT: begin
                    if (imem_ack) begin
                        instr <= imem_rdata;
                        state <= S_HOLD;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    // Acks arriving here are stray and deliberately ignored.
                    if (consume) begin
                        pc      <= next_pc;
                        retired <= retired + 32'd1;
                        state   <= S_REQ;
                    end
                end
                default: state <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a transaction-level model (held/not-held, pc, instr, retired count).
module tb_fetch_unit;

    localparam logic [31:0] RST_PC   = 32'h0000_0000;
    localparam logic [31:0] RST_PC_W = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_ack, instr_ready, PCsrc;
    logic [31:0] imem_rdata, ImmOp;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, retired;
    logic        w_imem_req, w_instr_valid;
    logic [31:0] w_imem_addr, w_instr, w_pc, w_retired;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: is an instruction held, which pc, which word, how many consumed.
    logic [31:0] m_pc, m_instr, m_retired;
    bit          m_valid;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .PCsrc(PCsrc),
        .ImmOp(ImmOp), .pc(pc), .retired(retired)
    );

    fetch_unit #(.RESET_PC(RST_PC_W)) dut_w (
        .clk(clk), .rst_n(rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(w_instr),
        .instr_valid(w_instr_valid), .instr_ready(instr_ready), .PCsrc(PCsrc),
        .ImmOp(ImmOp), .pc(w_pc), .retired(w_retired)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic drive(input bit ack, input bit rdy, input bit src, input logic [31:0] imm);
        imem_ack    = ack;
        instr_ready = rdy;
        PCsrc       = src;
        ImmOp       = imm;
        imem_rdata  = mem_word(m_pc);
    endtask

    // Advance one clock, updating the model from the inputs currently driven.
    task automatic tick();
        logic [31:0] t_pc, t_instr, t_ret;
        bit          t_v;
        t_pc = m_pc; t_instr = m_instr; t_ret = m_retired; t_v = m_valid;
        if (!rst_n) begin
            t_pc = RST_PC; t_instr = '0; t_ret = '0; t_v = 1'b0;
        end else if (m_valid) begin
            if (instr_ready) begin
                t_pc  = (PCsrc ? m_pc + ImmOp : m_pc + 32'd4) & 32'hFFFF_FFFC;
                t_ret = m_retired + 32'd1;
                t_v   = 1'b0;
            end
        end else if (imem_ack) begin
            t_instr = imem_rdata;
            t_v     = 1'b1;
        end
        @(posedge clk);
        m_pc = t_pc; m_instr = t_instr; m_retired = t_ret; m_valid = t_v;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0040);
        tick();
        tick();
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else n_pass++;
        n_checks++; if (pc !== RST_PC) $display("FAIL reset_pc: got %h want %h", pc, RST_PC); else n_pass++;
        n_checks++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", instr); else n_pass++;
        n_checks++; if (retired !== 32'h0) $display("FAIL reset_retired: got %h want 0", retired); else n_pass++;
        n_checks++; if (w_pc !== RST_PC_W) $display("FAIL reset_pc_param: got %h want %h", w_pc, RST_PC_W); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL reset_release_req: got %b want 1", imem_req); else n_pass++;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b0, $urandom);
            tick();
            n_checks++; if (pc !== m_pc) $display("FAIL seq_pc[%0d]: got %h want %h", i, pc, m_pc); else n_pass++;
            n_checks++; if (instr_valid !== m_valid) $display("FAIL seq_valid[%0d]: got %b want %b", i, instr_valid, m_valid); else n_pass++;
            n_checks++; if (instr !== m_instr) $display("FAIL seq_instr[%0d]: got %h want %h", i, instr, m_instr); else n_pass++;
        end
        n_checks++; if (retired !== 32'd4) $display("FAIL seq_retired: got %0d want 4", retired); else n_pass++;
        n_checks++; if (pc !== 32'h10) $display("FAIL seq_final_pc: got %h want 10", pc); else n_pass++;
        n_checks++; if (w_pc !== 32'h0000_000C) $display("FAIL seq_wrap_pc: got %h want 0000000c", w_pc); else n_pass++;
    endtask

    task automatic test_branch();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        n_checks++; if (instr !== mem_word(32'h10)) $display("FAIL branch_instr: got %h want %h", instr, mem_word(32'h10)); else n_pass++;
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        tick();
        n_checks++; if (imem_addr !== 32'h08) $display("FAIL branch_addr: got %h want 08", imem_addr); else n_pass++;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL branch_req: got %b want 1", imem_req); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [31:0] saved;
        saved = m_pc;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, $urandom);
            tick();
            n_checks++; if (imem_addr !== saved) $display("FAIL wait_addr[%0d]: got %h want %h", i, imem_addr, saved); else n_pass++;
            n_checks++; if (imem_req !== 1'b1 || instr_valid !== 1'b0)
                $display("FAIL wait_req_valid[%0d]: got %b%b want 10", i, imem_req, instr_valid); else n_pass++;
            n_checks++; if (retired !== m_retired) $display("FAIL wait_retired[%0d]: got %0d want %0d", i, retired, m_retired); else n_pass++;
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        n_checks++; if (instr !== mem_word(saved)) $display("FAIL late_ack_instr: got %h want %h", instr, mem_word(saved)); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom), 1'b0, 1'b1, $urandom);
            tick();
            n_checks++; if (instr !== m_instr || pc !== saved)
                $display("FAIL hold_stable[%0d]: got %h/%h want %h/%h", i, instr, pc, m_instr, saved); else n_pass++;
            n_checks++; if (imem_req !== 1'b0 || instr_valid !== 1'b1)
                $display("FAIL hold_req_valid[%0d]: got %b%b want 01", i, imem_req, instr_valid); else n_pass++;
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        n_checks++; if (pc !== saved + 32'd4) $display("FAIL release_pc: got %h want %h", pc, saved + 32'd4); else n_pass++;
    endtask

    task automatic test_spurious_ack();
        logic [31:0] held, base;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        held = m_instr;
        base = m_pc;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        imem_rdata = ~held;
        tick();
        n_checks++; if (instr !== held) $display("FAIL spurious_instr: got %h want %h", instr, held); else n_pass++;
        n_checks++; if (instr_valid !== 1'b1) $display("FAIL spurious_valid: got %b want 1", instr_valid); else n_pass++;
        drive(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0000_0100);
        tick();
        n_checks++; if (pc !== base + 32'd4) $display("FAIL ignored_branch_pc: got %h want %h", pc, base + 32'd4); else n_pass++;
    endtask

    task automatic test_wrap_align();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h20 - m_pc);
        tick();
        n_checks++; if (pc !== 32'h20) $display("FAIL goto_20_pc: got %h want 20", pc); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h6);
        tick();
        n_checks++; if (pc !== 32'h24) $display("FAIL align_pc: got %h want 24", pc); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFD8);
        tick();
        n_checks++; if (pc !== 32'hFFFF_FFFC) $display("FAIL top_pc: got %h want fffffffc", pc); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        n_checks++; if (pc !== 32'h0) $display("FAIL wrap_pc: got %h want 0", pc); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b1, 32'h40 - m_pc);
        tick();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        n_checks++; if (pc !== 32'h40 || instr_valid !== 1'b1)
            $display("FAIL hold_at_40: got %h/%b want 40/1", pc, instr_valid); else n_pass++;
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b1, $urandom);
        tick();
        n_checks++; if (pc !== RST_PC) $display("FAIL rst_hold_pc: got %h want %h", pc, RST_PC); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b0)
            $display("FAIL rst_hold_outs: got %b%b want 00", instr_valid, imem_req); else n_pass++;
        n_checks++; if (retired !== 32'h0) $display("FAIL rst_hold_retired: got %0d want 0", retired); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL rst_hold_rereq: got %b want 1", imem_req); else n_pass++;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        tick();
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        n_checks++; if (pc !== RST_PC || instr !== 32'h0)
            $display("FAIL rst_wait: got %h/%h want %h/0", pc, instr, RST_PC); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(49) != 0);
            drive($urandom_range(2) != 0, 1'($urandom), 1'($urandom), $urandom);
            if (m_valid && $urandom_range(1) == 1) imem_rdata = $urandom;
            tick();
            n_checks++; if (pc !== m_pc || imem_addr !== m_pc)
                $display("FAIL rand_pc[%0d]: got %h/%h want %h", i, pc, imem_addr, m_pc); else n_pass++;
            n_checks++; if (instr !== m_instr) $display("FAIL rand_instr[%0d]: got %h want %h", i, instr, m_instr); else n_pass++;
            n_checks++; if (retired !== m_retired) $display("FAIL rand_retired[%0d]: got %0d want %0d", i, retired, m_retired); else n_pass++;
            n_checks++; if (instr_valid !== (rst_n && m_valid) || imem_req !== (rst_n && !m_valid))
                $display("FAIL rand_hs[%0d]: got v=%b r=%b want v=%b r=%b", i, instr_valid, imem_req,
                         rst_n && m_valid, rst_n && !m_valid); else n_pass++;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        PCsrc       = 1'b0;
        ImmOp       = '0;
        imem_rdata  = '0;
        m_pc        = RST_PC;
        m_instr     = '0;
        m_retired   = '0;
        m_valid     = 1'b0;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch();
        test_backpressure();
        test_spurious_ack();
        test_wrap_align();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
